mbist_march_ctrl: RTL and testbench

March C- BIST initiator that drives the single-port `fault_mem` test memory (`write_read`, `address`, `wdata`) and checks its `rdata` return path. It sits between the chip-level test controller (`start`/`done`/`fail`) and the memory under test. It reports pass/fail, the first failing address, the first failing march element and the first failing read data. Its memory-side timing is matched to the memory's registered write data and its two-cycle read pipeline.

---
 rtl/mbist_pkg.sv | 27 ++
 rtl/mbist_addr_gen.sv | 34 +++
 rtl/mbist_march_ctrl.sv | 147 ++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mbist_pkg.sv
// Shared types and March C- element tables for the MBIST controller.
// Element k of each packed table is bit k.
package mbist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WS,
        WW,
        RD,
        RW,
        RC,
        DONE
    } state_t;

    localparam int unsigned NUM_ELEMS    = 6;
    localparam int unsigned FAIL_COUNT_W = 8;

    // 1 = descending address order
    localparam logic [NUM_ELEMS-1:0] ELEM_DOWN       = 6'b011000;
    // Every element except E0 starts with a read
    localparam logic [NUM_ELEMS-1:0] ELEM_READ_FIRST = 6'b111110;
    localparam logic [1:0]           ELEM_OPS [NUM_ELEMS] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
    // Background expected by the read and written by the write of each element
    localparam logic [NUM_ELEMS-1:0] ELEM_EXP_BG     = 6'b010100;
    localparam logic [NUM_ELEMS-1:0] ELEM_WR_BG      = 6'b001010;

endpackage

// File: rtl/mbist_addr_gen.sv
// Up/down address counter over 0..CAPACITY-1; direction is latched on load.
module mbist_addr_gen #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned CAPACITY   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  dir,
    input  logic                  step,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    localparam logic [ADDR_WIDTH-1:0] TOP = ADDR_WIDTH'(CAPACITY - 1);

    logic down;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= '0;
            down <= 1'b0;
        end else if (load) begin
            addr <= dir ? TOP : '0;
            down <= dir;
        end else if (step) begin
            addr <= down ? addr - 1'b1 : addr + 1'b1;
        end
    end

    // Latching the direction keeps last independent of the next element's dir
    assign last = down ? (addr == '0) : (addr == TOP);

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- BIST controller for the fault_mem test memory.
// Optional: define MBIST_STOP_ON_FAIL_EN to end the test at the first mismatch.
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned CAPACITY   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    fail,
    output logic [ADDR_WIDTH-1:0]   fail_addr,
    output logic [2:0]              fail_elem,
    output logic [DATA_WIDTH-1:0]   fail_data,
    output logic [FAIL_COUNT_W-1:0] fail_count,
    output logic                    mem_write_read,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

`ifdef MBIST_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    localparam logic [2:0] LAST_ELEM = 3'(NUM_ELEMS - 1);

    state_t     state, next_state;
    logic [2:0] elem, next_elem;
    logic       op, next_op;
    logic       ag_load, ag_dir, ag_step, ag_last;
    logic       accept, mismatch, last_op;

    mbist_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .CAPACITY   (CAPACITY)
    ) u_addr_gen (
        .clk  (clk),
        .rst  (rst),
        .load (ag_load),
        .dir  (ag_dir),
        .step (ag_step),
        .addr (mem_address),
        .last (ag_last)
    );

    always_comb begin
        next_state = state;
        next_elem  = elem;
        next_op    = op;
        ag_load    = 1'b0;
        ag_step    = 1'b0;
        ag_dir     = 1'b0;
        accept     = start && (state == IDLE || state == DONE);
        mismatch   = (state == RC) && (mem_rdata != {DATA_WIDTH{ELEM_EXP_BG[elem]}});
        last_op    = op || (ELEM_OPS[elem] == 2'd1);

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    next_state = WS;
                    next_elem  = '0;
                    next_op    = 1'b0;
                    ag_load    = 1'b1;
                    ag_dir     = ELEM_DOWN[0];
                end
            end
            WS: next_state = WW;
            RD: next_state = RW;
            RW: next_state = RC;
            WW, RC: begin
                if (STOP_ON_FAIL && mismatch) begin
                    next_state = DONE;
                end else if (!last_op) begin
                    // the second operation of a two-op element is always a write
                    next_op    = 1'b1;
                    next_state = WS;
                end else if (!ag_last) begin
                    ag_step    = 1'b1;
                    next_op    = 1'b0;
                    next_state = ELEM_READ_FIRST[elem] ? RD : WS;
                end else if (elem != LAST_ELEM) begin
                    next_elem  = elem + 3'd1;
                    next_op    = 1'b0;
                    ag_load    = 1'b1;
                    ag_dir     = ELEM_DOWN[elem + 3'd1];
                    next_state = ELEM_READ_FIRST[elem + 3'd1] ? RD : WS;
                end else begin
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            elem           <= '0;
            op             <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            fail           <= 1'b0;
            fail_addr      <= '0;
            fail_elem      <= '0;
            fail_data      <= '0;
            fail_count     <= '0;
            mem_write_read <= 1'b0;
            mem_wdata      <= '0;
        end else begin
            state          <= next_state;
            elem           <= next_elem;
            op             <= next_op;
            // outputs are registered from the next state so they align with it
            busy           <= (next_state != IDLE) && (next_state != DONE);
            done           <= (next_state == DONE);
            mem_write_read <= (next_state == WW);
            if (next_state == WS) begin
                mem_wdata <= {DATA_WIDTH{ELEM_WR_BG[next_elem]}};
            end
            if (accept) begin
                fail       <= 1'b0;
                fail_addr  <= '0;
                fail_elem  <= '0;
                fail_data  <= '0;
                fail_count <= '0;
            end else if (mismatch) begin
                fail <= 1'b1;
                if (fail_count != '1) begin
                    fail_count <= fail_count + 1'b1;
                end
                if (!fail) begin
                    fail_addr <= mem_address;
                    fail_elem <= elem;
                    fail_data <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Self-checking bench: behavioural fault memories plus a March C- reference run on an array.
module tb_mbist_march_ctrl;

    localparam int DW   = 8;
    localparam int AW   = 4;
    localparam int CAP  = 16;
    localparam int AW2  = 1;
    localparam int CAP2 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, start = 1'b0, start2 = 1'b0;

    logic          busy, done, fail, wr1;
    logic [AW-1:0] fail_addr, addr1;
    logic [2:0]    fail_elem;
    logic [DW-1:0] fail_data, wdata1, rdata1;
    logic [7:0]    fail_count;

    logic           busy2, done2, fail2, wr2;
    logic [AW2-1:0] fail_addr2, addr2;
    logic [2:0]     fail_elem2;
    logic [DW-1:0]  fail_data2, wdata2, rdata2;
    logic [7:0]     fail_count2;

    mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAPACITY(CAP)) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .fail(fail),
        .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_data(fail_data),
        .fail_count(fail_count), .mem_write_read(wr1), .mem_address(addr1),
        .mem_wdata(wdata1), .mem_rdata(rdata1)
    );

    mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW2), .CAPACITY(CAP2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .fail(fail2),
        .fail_addr(fail_addr2), .fail_elem(fail_elem2), .fail_data(fail_data2),
        .fail_count(fail_count2), .mem_write_read(wr2), .mem_address(addr2),
        .mem_wdata(wdata2), .mem_rdata(rdata2)
    );

    int checks = 0, errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Fault environment: kind 0 none, 1 stuck bit, 2 write to f_a also writes f_vic
    int f_kind = 0, f_a = 0, f_b = 0, f_v = 0, f_vic = 1;

    function automatic logic [7:0] stored(input int a, input logic [7:0] d);
        logic [7:0] r;
        r = d;
        if (f_kind == 1 && a == f_a) r[f_b] = f_v[0];
        return r;
    endfunction

    logic [7:0]    mem1 [CAP];
    logic [7:0]    wq1;
    logic [AW-1:0] aq1;
    always @(posedge clk) begin
        wq1    <= wdata1;
        aq1    <= addr1;
        rdata1 <= mem1[aq1];
        if (wr1) begin
            mem1[addr1] <= stored(int'(addr1), wq1);
            if (f_kind == 2 && int'(addr1) == f_a) mem1[f_vic] <= stored(f_vic, wq1);
        end
    end

    logic [7:0]     mem2 [CAP2];
    logic [7:0]     wq2;
    logic [AW2-1:0] aq2;
    always @(posedge clk) begin
        wq2    <= wdata2;
        aq2    <= addr2;
        rdata2 <= mem2[aq2];
        if (wr2) mem2[addr2] <= wq2;
    end

    // Reference model: March C- run on a plain array, producing results and per-cycle bus
    typedef struct {
        int         addr;
        bit         wr;
        bit         chk_data;
        logic [7:0] data;
    } cyc_t;

    cyc_t       exp_q [$];
    int         e_down [6] = '{0, 0, 0, 1, 1, 0};
    int         e_rd   [6] = '{-1, 0, 1, 0, 1, 0};
    int         e_wr   [6] = '{0, 1, 0, 1, 0, -1};
    bit         exp_fail;
    int         exp_addr, exp_elem, exp_count, exp_cycles;
    logic [7:0] exp_data;

    task automatic push_cyc(input int a, input bit w, input bit c, input logic [7:0] d);
        cyc_t x;
        x.addr = a; x.wr = w; x.chk_data = c; x.data = d;
        exp_q.push_back(x);
    endtask

    task automatic run_model(input int cap);
        logic [7:0] m [16];
        logic [7:0] bg, v;
        int a;
        bit stop;
        stop = 0;
        exp_fail = 0; exp_addr = 0; exp_elem = 0; exp_count = 0; exp_cycles = 0; exp_data = '0;
        exp_q.delete();
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < cap; k++) begin
                if (!stop) begin
                    a = e_down[e] ? cap - 1 - k : k;
                    if (e_rd[e] >= 0) begin
                        bg = e_rd[e] ? 8'hFF : 8'h00;
                        v  = m[a];
                        for (int c = 0; c < 3; c++) push_cyc(a, 0, 0, 8'h00);
                        exp_cycles += 3;
                        if (v !== bg) begin
                            if (exp_count < 255) exp_count++;
                            if (!exp_fail) begin
                                exp_addr = a; exp_elem = e; exp_data = v;
                            end
                            exp_fail = 1;
`ifdef MBIST_STOP_ON_FAIL_EN
                            stop = 1;
`endif
                        end
                    end
                    if (!stop && e_wr[e] >= 0) begin
                        bg = e_wr[e] ? 8'hFF : 8'h00;
                        push_cyc(a, 0, 1, bg);
                        push_cyc(a, 1, 1, bg);
                        exp_cycles += 2;
                        m[a] = stored(a, bg);
                        if (f_kind == 2 && a == f_a) m[f_vic] = stored(f_vic, bg);
                    end
                end
            end
        end
    endtask

    // Bus checker: every busy cycle is matched against the model's cycle list
    int         sel = 0;
    bit         mon_en = 0;
    logic [7:0] prev_wdata = '0;
    always @(negedge clk) begin
        logic       mb, mw;
        int         ma;
        logic [7:0] md;
        cyc_t       c;
        if (sel == 0) begin mb = busy;  mw = wr1; ma = int'(addr1); md = wdata1; end
        else          begin mb = busy2; mw = wr2; ma = int'(addr2); md = wdata2; end
        if (mon_en) begin
            if (mb) begin
                if (exp_q.size() == 0) begin
                    check_val("bus_extra_cycle", 1, 0);
                end else begin
                    c = exp_q.pop_front();
                    check_val("bus_addr", 64'(ma), 64'(c.addr));
                    check_val("bus_write_read", {63'd0, mw}, {63'd0, c.wr});
                    if (c.chk_data) check_val("bus_wdata", {56'd0, md}, {56'd0, c.data});
                    if (mw) check_val("wdata_stable", {56'd0, md}, {56'd0, prev_wdata});
                end
            end else begin
                check_val("write_when_idle", {63'd0, mw}, 64'd0);
            end
        end
        prev_wdata <= md;
    end

    task automatic check_all_zero(input string tag);
        check_val({tag, "_busy"}, {63'd0, busy}, 0);
        check_val({tag, "_done"}, {63'd0, done}, 0);
        check_val({tag, "_fail"}, {63'd0, fail}, 0);
        check_val({tag, "_fail_addr"}, 64'(fail_addr), 0);
        check_val({tag, "_fail_elem"}, 64'(fail_elem), 0);
        check_val({tag, "_fail_data"}, 64'(fail_data), 0);
        check_val({tag, "_fail_count"}, 64'(fail_count), 0);
        check_val({tag, "_mem_wr"}, {63'd0, wr1}, 0);
        check_val({tag, "_mem_addr"}, 64'(addr1), 0);
        check_val({tag, "_mem_wdata"}, 64'(wdata1), 0);
    endtask

    task automatic run_dut1(input string tag, input bit glitch);
        int n;
        sel = 0;
        run_model(CAP);
        mon_en = 1;
        repeat ($urandom_range(0, 4)) @(negedge clk);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check_val({tag, "_busy_after_start"}, {63'd0, busy}, 1);
        check_val({tag, "_fail_cleared"}, {63'd0, fail}, 0);
        check_val({tag, "_count_cleared"}, 64'(fail_count), 0);
        n = 0;
        while (!done && n < 2000) begin
            @(posedge clk);
            #1 n++;
            start = glitch && (n == 10 || n == 50);
        end
        start = 1'b0;
        mon_en = 0;
        check_val({tag, "_cycles"}, 64'(n), 64'(exp_cycles));
        check_val({tag, "_busy_end"}, {63'd0, busy}, 0);
        check_val({tag, "_fail"}, {63'd0, fail}, {63'd0, exp_fail});
        check_val({tag, "_fail_count"}, 64'(fail_count), 64'(exp_count));
        if (exp_fail) begin
            check_val({tag, "_fail_addr"}, 64'(fail_addr), 64'(exp_addr));
            check_val({tag, "_fail_elem"}, 64'(fail_elem), 64'(exp_elem));
            check_val({tag, "_fail_data"}, 64'(fail_data), 64'(exp_data));
        end
        check_val({tag, "_bus_left"}, 64'(exp_q.size()), 0);
    endtask

    initial begin
        int n;
        // rst wins over a simultaneous start
        rst = 1'b1; start = 1'b1;
        repeat (2) @(posedge clk);
        #1 start = 1'b0;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1 check_val("idle_no_start_busy", {63'd0, busy}, 0);

        f_kind = 0;
        run_dut1("clean", 0);
        check_val("clean_cycles_400", 64'(exp_cycles), 400);

        f_kind = 1; f_a = 5; f_b = 6; f_v = 0;
        run_dut1("stuck", 0);
        check_val("stuck_addr5", 64'(fail_addr), 5);
        check_val("stuck_data_bf", 64'(fail_data), 64'hBF);
`ifdef MBIST_STOP_ON_FAIL_EN
        check_val("stuck_count", 64'(fail_count), 1);
`else
        check_val("stuck_count", 64'(fail_count), 2);
`endif
        run_dut1("stuck_rerun_glitch", 1);

        f_kind = 2; f_a = 3; f_vic = 4;
        run_dut1("couple", 0);
        check_val("couple_addr4", 64'(fail_addr), 4);
        check_val("couple_elem1", 64'(fail_elem), 1);

        // Reset in the middle of a failing run discards everything
        sel = 0;
        run_model(CAP);
        mon_en = 1;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (n < 137) begin @(posedge clk); #1 n++; end
        check_val("mid_fail_before_rst", {63'd0, fail}, 1);
        mon_en = 0;
        rst = 1'b1;
        @(posedge clk);
        #1 check_all_zero("mid_rst");
        rst = 1'b0;
        exp_q.delete();
        f_kind = 0;
        run_dut1("after_rst", 0);

        for (int r = 0; r < 4; r++) begin
            f_kind = $urandom_range(0, 2);
            f_a    = $urandom_range(0, CAP - 1);
            f_b    = $urandom_range(0, DW - 1);
            f_v    = $urandom_range(0, 1);
            f_vic  = (f_a + 1 + $urandom_range(0, CAP - 2)) % CAP;
            run_dut1($sformatf("rand%0d", r), r[0]);
        end

        // Two-word memory: full sequence and boundaries on the small instance
        f_kind = 0;
        sel = 1;
        run_model(CAP2);
        mon_en = 1;
        @(negedge clk) start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        n = 0;
        while (!done2 && n < 500) begin @(posedge clk); #1 n++; end
        mon_en = 0;
        check_val("cap2_cycles", 64'(n), 64'(exp_cycles));
        check_val("cap2_cycles_50", 64'(exp_cycles), 50);
        check_val("cap2_fail", {63'd0, fail2}, 0);
        check_val("cap2_count", 64'(fail_count2), 0);
        check_val("cap2_bus_left", 64'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
